// File: rtl/executor_rega.sv
// Irrigation actuator: sequences pump and valves through prime, irrigate and purge phases.
// Define CONTADOR_REGAS_EN to build the saturating completed-run counter on n_regas.
module executor_rega #(
    parameter int unsigned T_PRE   = 2,
    parameter int unsigned T_ASP   = 8,
    parameter int unsigned T_GOT   = 16,
    parameter int unsigned T_PURGA = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rega,
    input  logic       erro,
    input  logic       VE,
    output logic       valv_asp,
    output logic       valv_got,
    output logic       bomba,
    output logic       ocupado,
    output logic       concluido,
    output logic       abortado,
    output logic [1:0] estado,
    output logic [7:0] n_regas
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRE   = 2'b01,
        REGA  = 2'b10,
        PURGA = 2'b11
    } state_e;

    // Counters are loaded with T-1 so a phase lasts exactly T cycles.
    localparam logic [CNT_W-1:0] LD_PRE   = CNT_W'(T_PRE - 1);
    localparam logic [CNT_W-1:0] LD_ASP   = CNT_W'(T_ASP - 1);
    localparam logic [CNT_W-1:0] LD_GOT   = CNT_W'(T_GOT - 1);
    localparam logic [CNT_W-1:0] LD_PURGA = CNT_W'(T_PURGA - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             asp_q, asp_d;
    logic             abt_q, abt_d;
    logic             concl_q, concl_d;
    logic             abort_q, abort_d;
    logic             bomba_q, bomba_d;
    logic             vasp_q, vasp_d;
    logic             vgot_q, vgot_d;
    logic             ocup_q, ocup_d;
    logic             fault_c;
    logic             start_c;
    logic             cnt_zero_c;

    assign fault_c    = erro | VE;
    assign start_c    = ~fault_c & ((rega == 2'b10) | (rega == 2'b01));
    assign cnt_zero_c = (cnt_q == '0);

    // Next-state, phase counter and registered-output targets.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asp_d   = asp_q;
        abt_d   = abt_q;
        concl_d = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d = PRE;
                    cnt_d   = LD_PRE;
                    asp_d   = rega[1];
                    abt_d   = 1'b0;
                end
            end
            PRE: begin
                if (fault_c) begin
                    state_d = PURGA;
                    cnt_d   = LD_PURGA;
                    abt_d   = 1'b1;
                    abort_d = 1'b1;
                end else if (cnt_zero_c) begin
                    state_d = REGA;
                    cnt_d   = asp_q ? LD_ASP : LD_GOT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REGA: begin
                if (fault_c) begin
                    state_d = PURGA;
                    cnt_d   = LD_PURGA;
                    abt_d   = 1'b1;
                    abort_d = 1'b1;
                end else if (cnt_zero_c) begin
                    state_d = PURGA;
                    cnt_d   = LD_PURGA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PURGA: begin
                // Faults are ignored here: the purge always runs to completion.
                if (cnt_zero_c) begin
                    state_d = IDLE;
                    concl_d = ~abt_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        bomba_d = (state_d == PRE) | (state_d == REGA);
        vasp_d  = asp_d & ((state_d == REGA) | (state_d == PURGA));
        vgot_d  = ~asp_d & ((state_d == REGA) | (state_d == PURGA));
        ocup_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asp_q   <= 1'b0;
            abt_q   <= 1'b0;
            concl_q <= 1'b0;
            abort_q <= 1'b0;
            bomba_q <= 1'b0;
            vasp_q  <= 1'b0;
            vgot_q  <= 1'b0;
            ocup_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asp_q   <= asp_d;
            abt_q   <= abt_d;
            concl_q <= concl_d;
            abort_q <= abort_d;
            bomba_q <= bomba_d;
            vasp_q  <= vasp_d;
            vgot_q  <= vgot_d;
            ocup_q  <= ocup_d;
        end
    end

    assign estado    = state_q;
    assign bomba     = bomba_q;
    assign valv_asp  = vasp_q;
    assign valv_got  = vgot_q;
    assign ocupado   = ocup_q;
    assign concluido = concl_q;
    assign abortado  = abort_q;

`ifdef CONTADOR_REGAS_EN
    logic [7:0] n_regas_q;

    // Advances together with the concluido pulse; saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_regas_q <= 8'h00;
        end else if (concl_d && (n_regas_q != 8'hFF)) begin
            n_regas_q <= n_regas_q + 8'd1;
        end
    end

    assign n_regas = n_regas_q;
`else
    assign n_regas = 8'h00;
`endif

endmodule

// File: tb/tb_executor_rega.sv
// Randomized self-checking bench for executor_rega; expected output traces are built per run.
`timescale 1ns/1ps
module tb_executor_rega;

    localparam int T_PRE   = 2;
    localparam int T_ASP   = 8;
    localparam int T_GOT   = 16;
    localparam int T_PURGA = 3;
    localparam int NSCN    = 12;
`ifdef CONTADOR_REGAS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] rega;
    logic       erro;
    logic       VE;
    logic       valv_asp;
    logic       valv_got;
    logic       bomba;
    logic       ocupado;
    logic       concluido;
    logic       abortado;
    logic [1:0] estado;
    logic [7:0] n_regas;
    logic [15:0] obs;

    int total = 0;
    int bad   = 0;
    logic [7:0]  nreg = 8'h00;
    logic [15:0] exp_q[$];

    executor_rega #(
        .T_PRE(T_PRE), .T_ASP(T_ASP), .T_GOT(T_GOT), .T_PURGA(T_PURGA), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rega(rega), .erro(erro), .VE(VE),
        .valv_asp(valv_asp), .valv_got(valv_got), .bomba(bomba),
        .ocupado(ocupado), .concluido(concluido), .abortado(abortado),
        .estado(estado), .n_regas(n_regas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {estado, bomba, valv_asp, valv_got, ocupado, concluido, abortado, n_regas};

    // Expected observation vector from phase, mode and pulse flags.
    function automatic logic [15:0] pk(input logic [1:0] st, input bit asp, input bit c,
                                       input bit a, input logic [7:0] n);
        bit busy;
        bit pump;
        bit wet;
        busy = (st != 2'b00);
        pump = (st == 2'b01) || (st == 2'b10);
        wet  = (st == 2'b10) || (st == 2'b11);
        return {st, pump, wet & asp, wet & ~asp, busy, c, a, (CNT_EN ? n : 8'h00)};
    endfunction

    // ab < 0: normal run; otherwise a fault is presented right after observation ab.
    task automatic build_trace(input bit asp, input int ab);
        int run;
        run = asp ? T_ASP : T_GOT;
        exp_q.delete();
        if (ab < 0) begin
            repeat (T_PRE)   exp_q.push_back(pk(2'b01, asp, 1'b0, 1'b0, nreg));
            repeat (run)     exp_q.push_back(pk(2'b10, asp, 1'b0, 1'b0, nreg));
            repeat (T_PURGA) exp_q.push_back(pk(2'b11, asp, 1'b0, 1'b0, nreg));
            if (nreg != 8'hFF) nreg = nreg + 8'd1;
            exp_q.push_back(pk(2'b00, asp, 1'b1, 1'b0, nreg));
        end else begin
            for (int i = 0; i <= ab; i++)
                exp_q.push_back(pk((i < T_PRE) ? 2'b01 : 2'b10, asp, 1'b0, 1'b0, nreg));
            for (int i = 0; i < T_PURGA; i++)
                exp_q.push_back(pk(2'b11, asp, 1'b0, (i == 0), nreg));
            exp_q.push_back(pk(2'b00, asp, 1'b0, 1'b0, nreg));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; rega = 2'b00; erro = 1'b0; VE = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 16'h0000) begin
            bad++; $display("FAIL reset_hold got=%b exp=%b", obs, 16'h0000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 16'h0000) begin
            bad++; $display("FAIL reset_release got=%b exp=%b", obs, 16'h0000);
        end
    endtask

    task automatic test_ignored();
        logic [3:0] pats [6];
        pats = '{4'b1100, 4'b1010, 4'b0101, 4'b1001, 4'b0110, 4'b0000};
        for (int p = 0; p < 6; p++) begin
            {rega, erro, VE} = pats[p];
            repeat (2) begin
                @(negedge clk);
                total++;
                if (obs !== pk(2'b00, 1'b0, 1'b0, 1'b0, nreg)) begin
                    bad++;
                    $display("FAIL ignored pat=%b got=%b exp=%b", pats[p], obs,
                             pk(2'b00, 1'b0, 1'b0, 1'b0, nreg));
                end
            end
        end
        {rega, erro, VE} = 4'b0000;
    endtask

    task automatic test_runs();
        for (int s = 0; s < NSCN; s++) begin
            bit asp;
            int ab;
            bit noise;
            bit use_ve;
            int run;
            case (s)
                0: begin asp = 1'b1; ab = -1;        noise = 1'b0; use_ve = 1'b1; end
                1: begin asp = 1'b0; ab = -1;        noise = 1'b0; use_ve = 1'b1; end
                2: begin asp = 1'b1; ab = T_PRE + 3; noise = 1'b0; use_ve = 1'b1; end
                3: begin asp = 1'b1; ab = -1;        noise = 1'b0; use_ve = 1'b1; end
                default: begin
                    asp    = 1'($urandom);
                    run    = asp ? T_ASP : T_GOT;
                    ab     = ($urandom_range(0, 1) == 0) ? -1
                             : int'($urandom_range(0, T_PRE + run - 1));
                    noise  = 1'b1;
                    use_ve = 1'($urandom);
                end
            endcase
            build_trace(asp, ab);
            rega = asp ? 2'b10 : 2'b01; erro = 1'b0; VE = 1'b0;
            for (int k = 0; k < exp_q.size(); k++) begin
                @(negedge clk);
                total++;
                if (obs !== exp_q[k]) begin
                    bad++;
                    $display("FAIL run s=%0d step=%0d got=%b exp=%b", s, k, obs, exp_q[k]);
                end
                rega = noise ? 2'($urandom) : (asp ? 2'b01 : 2'b10);
                erro = 1'b0; VE = 1'b0;
                if (k == ab) begin
                    if (use_ve) VE = 1'b1; else erro = 1'b1;
                end else if (ab >= 0 && k > ab && noise) begin
                    erro = 1'($urandom); VE = 1'($urandom);
                end
                if (k == exp_q.size() - 1) begin
                    rega = 2'b00; erro = 1'b0; VE = 1'b0;
                end
            end
            @(negedge clk);
            total++;
            if (obs !== pk(2'b00, 1'b0, 1'b0, 1'b0, nreg)) begin
                bad++;
                $display("FAIL run_idle s=%0d got=%b exp=%b", s, obs,
                         pk(2'b00, 1'b0, 1'b0, 1'b0, nreg));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] first_q[$];
        build_trace(1'b0, -1);
        first_q = exp_q;
        build_trace(1'b0, -1);
        exp_q = {first_q, exp_q};
        rega = 2'b01; erro = 1'b0; VE = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[k]) begin
                bad++;
                $display("FAIL b2b step=%0d got=%b exp=%b", k, obs, exp_q[k]);
            end
            if (k == exp_q.size() - 1) rega = 2'b00;
        end
        @(negedge clk);
        total++;
        if (obs !== pk(2'b00, 1'b0, 1'b0, 1'b0, nreg)) begin
            bad++;
            $display("FAIL b2b_idle got=%b exp=%b", obs, pk(2'b00, 1'b0, 1'b0, 1'b0, nreg));
        end
    endtask

    task automatic test_reset_mid();
        rega = 2'b10; erro = 1'b0; VE = 1'b0;
        @(negedge clk);
        rega = 2'b00;
        repeat (T_PRE + 3) @(negedge clk);
        total++;
        if (obs !== pk(2'b10, 1'b1, 1'b0, 1'b0, nreg)) begin
            bad++;
            $display("FAIL mid_before got=%b exp=%b", obs, pk(2'b10, 1'b1, 1'b0, 1'b0, nreg));
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 16'h0000) begin
            bad++; $display("FAIL mid_async got=%b exp=%b", obs, 16'h0000);
        end
        nreg = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 16'h0000) begin
            bad++; $display("FAIL mid_after got=%b exp=%b", obs, 16'h0000);
        end
    endtask

    initial begin
        test_reset();
        test_ignored();
        test_runs();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
